// File: rtl/sap1_microsequencer.sv
// SAP-1 microsequencer: steps the decoder through microsteps under RUN / single-instruction /
// single-microstep / PAUSE control. Define SAP1_RETIRE_CNT_EN to add the retired-instruction counter.
module sap1_microsequencer #(
  parameter  int INSTRUCTION_STEPS = 8,
  parameter  int RETIRE_WIDTH      = 16,
  localparam int STEP_WIDTH        = $clog2(INSTRUCTION_STEPS)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [1:0]              i_mode,
  input  logic                    i_go,
  input  logic                    i_halt,
  input  logic                    i_adv,
  output logic [STEP_WIDTH-1:0]   o_step,
  output logic                    o_ctrl_en,
  output logic                    o_fetch,
  output logic                    o_halted,
`ifdef SAP1_RETIRE_CNT_EN
  output logic [RETIRE_WIDTH-1:0] o_retired,
`endif
  output logic                    o_go_ack
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'b00,
    S_EXEC   = 2'b01,
    S_HALTED = 2'b10
  } state_e;

  localparam logic [1:0]            MODE_RUN  = 2'b00;
  localparam logic [1:0]            MODE_INSN = 2'b01;
  localparam logic [1:0]            MODE_PAUSE = 2'b11;
  localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);
  localparam logic [STEP_WIDTH-1:0] STEP_ONE  = STEP_WIDTH'(1);

  state_e                  state_q;
  logic [STEP_WIDTH-1:0]   step_q;
  logic                    go_prev_q;
  logic                    go_ack_q;
  logic                    go_edge;
  logic                    boundary;
`ifdef SAP1_RETIRE_CNT_EN
  logic [RETIRE_WIDTH-1:0] retired_q;
`endif

  assign go_edge  = i_go & ~go_prev_q;
  assign boundary = i_adv | (step_q == LAST_STEP);

  // History resets to 1 so a go held high across reset release is not taken as an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_WAIT;
      step_q    <= '0;
      go_prev_q <= 1'b1;
      go_ack_q  <= 1'b0;
`ifdef SAP1_RETIRE_CNT_EN
      retired_q <= '0;
`endif
    end else begin
      go_prev_q <= i_go;
      go_ack_q  <= 1'b0;
      unique case (state_q)
        S_WAIT: begin
          if (go_edge && (i_mode != MODE_PAUSE)) begin
            state_q  <= S_EXEC;
            go_ack_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (i_halt) begin
            state_q <= S_HALTED;
          end else begin
            step_q <= boundary ? '0 : (step_q + STEP_ONE);
`ifdef SAP1_RETIRE_CNT_EN
            if (boundary) retired_q <= retired_q + 1'b1;
`endif
            // Mode is sampled only here, so a change lands on a microstep boundary.
            if (i_mode == MODE_RUN)       state_q <= S_EXEC;
            else if (i_mode == MODE_INSN) state_q <= boundary ? S_WAIT : S_EXEC;
            else                          state_q <= S_WAIT;
          end
        end
        S_HALTED: state_q <= S_HALTED;
        default:  state_q <= S_WAIT;
      endcase
    end
  end

  assign o_step    = step_q;
  assign o_ctrl_en = (state_q == S_EXEC);
  assign o_fetch   = (state_q == S_EXEC) && (step_q == '0);
  assign o_halted  = (state_q == S_HALTED);
  assign o_go_ack  = go_ack_q;
`ifdef SAP1_RETIRE_CNT_EN
  assign o_retired = retired_q;
`endif

endmodule

// File: tb/tb_sap1_microsequencer.sv
// Directed bench for sap1_microsequencer; inputs change and outputs are checked 1 ns after each rising edge.
module tb_sap1_microsequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        go, halt, adv;
  logic [2:0]  step;
  logic        ctrl_en, fetch, halted, go_ack;
`ifdef SAP1_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  sap1_microsequencer #(.INSTRUCTION_STEPS(8), .RETIRE_WIDTH(16)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_mode    (mode),
    .i_go      (go),
    .i_halt    (halt),
    .i_adv     (adv),
    .o_step    (step),
    .o_ctrl_en (ctrl_en),
    .o_fetch   (fetch),
    .o_halted  (halted),
`ifdef SAP1_RETIRE_CNT_EN
    .o_retired (retired),
`endif
    .o_go_ack  (go_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    go = 1'b0; halt = 1'b0; adv = 1'b0; mode = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [2:0] seq032 [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};

  initial begin
    // Reset values
    rst_n = 1'b0;
    go = 1'b0; halt = 1'b0; adv = 1'b0; mode = 2'b00;
    tick();
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_ctrl_en", 32'(ctrl_en), 32'd0);
    chk("rst_fetch", 32'(fetch), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_go_ack", 32'(go_ack), 32'd0);
`ifdef SAP1_RETIRE_CNT_EN
    chk("rst_retired", 32'(retired), 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    chk("idle_ctrl_en", 32'(ctrl_en), 32'd0);

    // RUN mode, advance at step 4
    mode = 2'b00;
    go = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      chk("run_step", 32'(step), 32'(seq032[i]));
      chk("run_ctrl_en", 32'(ctrl_en), 32'd1);
      chk("run_go_ack", 32'(go_ack), (i == 0) ? 32'd1 : 32'd0);
      chk("run_fetch", 32'(fetch), (seq032[i] == 3'd0) ? 32'd1 : 32'd0);
      adv = (seq032[i] == 3'd4);
      tick();
    end
    adv = 1'b0;

    // Single-instruction mode, full 8-step slot
    do_reset();
    mode = 2'b01;
    go = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("insn_step", 32'(step), 32'(i));
      chk("insn_ctrl_en", 32'(ctrl_en), 32'd1);
      tick();
    end
    chk("insn_wait_ctrl_en", 32'(ctrl_en), 32'd0);
    chk("insn_wait_step", 32'(step), 32'd0);
    tick();
    chk("insn_hold_ctrl_en", 32'(ctrl_en), 32'd0);
`ifdef SAP1_RETIRE_CNT_EN
    chk("insn_retired", 32'(retired), 32'd1);
`endif

    // Single-microstep mode, three go edges 5 cycles apart
    do_reset();
    mode = 2'b10;
    for (int k = 0; k < 3; k++) begin
      go = 1'b1;
      tick();
      chk("ustep_ctrl_en", 32'(ctrl_en), 32'd1);
      chk("ustep_step", 32'(step), 32'(k));
      chk("ustep_go_ack", 32'(go_ack), 32'd1);
      go = 1'b0;
      for (int j = 0; j < 4; j++) begin
        tick();
        chk("ustep_idle_ctrl_en", 32'(ctrl_en), 32'd0);
      end
    end
    chk("ustep_final_step", 32'(step), 32'd3);

    // Halt wins over advance; halted ignores go
    do_reset();
    mode = 2'b00;
    go = 1'b1;
    tick();
    tick();
    tick();
    chk("halt_pre_step", 32'(step), 32'd2);
    halt = 1'b1;
    adv = 1'b1;
    tick();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_step", 32'(step), 32'd2);
    chk("halt_ctrl_en", 32'(ctrl_en), 32'd0);
    halt = 1'b0;
    adv = 1'b0;
    go = 1'b0;
    tick();
    go = 1'b1;
    tick();
    chk("halt_go_ack", 32'(go_ack), 32'd0);
    chk("halt_go_ctrl_en", 32'(ctrl_en), 32'd0);
    tick();
    chk("halt_still", 32'(halted), 32'd1);
    chk("halt_still_ctrl_en", 32'(ctrl_en), 32'd0);

    // Switch to PAUSE at step 3, then resume at step 4
    do_reset();
    mode = 2'b00;
    go = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("pause_pre_step", 32'(step), 32'd3);
    mode = 2'b11;
    tick();
    chk("pause_ctrl_en", 32'(ctrl_en), 32'd0);
    chk("pause_step", 32'(step), 32'd4);
    go = 1'b0;
    tick();
    go = 1'b1;
    tick();
    chk("pause_go_ack", 32'(go_ack), 32'd0);
    chk("pause_go_ctrl_en", 32'(ctrl_en), 32'd0);
    chk("pause_hold_step", 32'(step), 32'd4);
    go = 1'b0;
    mode = 2'b00;
    tick();
    go = 1'b1;
    tick();
    chk("resume_ctrl_en", 32'(ctrl_en), 32'd1);
    chk("resume_step", 32'(step), 32'd4);
    chk("resume_go_ack", 32'(go_ack), 32'd1);
    tick();
    chk("resume_next_step", 32'(step), 32'd5);

    // Asynchronous reset mid-run, go held high across release
    rst_n = 1'b0;
    #1;
    chk("arst_step", 32'(step), 32'd0);
    chk("arst_ctrl_en", 32'(ctrl_en), 32'd0);
    chk("arst_fetch", 32'(fetch), 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);
    chk("arst_go_ack", 32'(go_ack), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("arst_held_go_ctrl_en", 32'(ctrl_en), 32'd0);
    chk("arst_held_go_ack", 32'(go_ack), 32'd0);

`ifdef SAP1_RETIRE_CNT_EN
    // Retired counter wraps after 65537 single-step instructions
    do_reset();
    mode = 2'b00;
    adv = 1'b1;
    go = 1'b1;
    tick();
    for (int i = 0; i < 65537; i++) tick();
    chk("wrap_retired", 32'(retired), 32'd1);
    chk("wrap_step", 32'(step), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("wrap_arst_retired", 32'(retired), 32'd0);
    chk("wrap_arst_ctrl_en", 32'(ctrl_en), 32'd0);
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
